// File: rtl/layer_seq_ctrl_if.sv
// Bundle between a producing layer's parallel neuron outputs and the
// serialiser that feeds the next layer one word per cycle.
interface layer_seq_ctrl_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           in_valid;
    logic [NN*dataWidth-1:0] in_data;
    logic                    err_clr;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_out;
    logic                    busy;
    logic                    frame_done;
    logic                    err_overflow;
    logic                    err_partial;

    // Producer / environment side
    modport master (
        output in_valid, in_data, err_clr,
        input  x_valid, x_out, busy, frame_done, err_overflow, err_partial
    );

    // Serialiser side
    modport slave (
        input  in_valid, in_data, err_clr,
        output x_valid, x_out, busy, frame_done, err_overflow, err_partial
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Layer sequence controller: captures a full frame of NN neuron outputs when
// every strobe is high at once, then streams the words out serially, one per
// cycle. A new frame may be captured in the last streaming cycle so frames
// run back-to-back without a gap; captures earlier than that are dropped and
// flagged. All outputs are registered.
module layer_seq_ctrl #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input logic              clk,
    input logic              rst,
    layer_seq_ctrl_if.slave  bus
);
    localparam int             CW     = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0]  LAST   = CW'(NN - 1);
    localparam logic           SINGLE = (NN == 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [dataWidth-1:0] buf_q [NN];
    logic                 x_valid_q;
    logic [dataWidth-1:0] x_out_q;
    logic                 busy_q;
    logic                 frame_done_q;
    logic                 err_overflow_q;
    logic                 err_partial_q;

    logic cap;
    logic part;
    logic last_cyc;
    logic accept;
    logic overflow;

    // A capture needs every strobe in the same cycle; a strict subset is an error.
    assign cap      = &bus.in_valid;
    assign part     = (|bus.in_valid) & ~cap;
    // The last streaming cycle is the only SEND cycle that can take a new frame.
    assign last_cyc = (state_q == SEND) && (cnt_q == LAST);
    assign accept   = cap && ((state_q == IDLE) || last_cyc);
    assign overflow = cap && (state_q == SEND) && !last_cyc;
    assign cnt_d    = cnt_q + CW'(1);

    // Frame buffer: loaded only on an accepted capture; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NN; k++) begin
                buf_q[k] <= bus.in_data[k*dataWidth +: dataWidth];
            end
        end
    end

    // Control FSM with registered stream outputs and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            x_valid_q      <= 1'b0;
            x_out_q        <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            err_partial_q  <= 1'b0;
        end else begin
            if (accept) begin
                // Word 0 comes straight from the input so it appears the cycle after capture.
                state_q      <= SEND;
                cnt_q        <= '0;
                x_valid_q    <= 1'b1;
                x_out_q      <= bus.in_data[0 +: dataWidth];
                busy_q       <= 1'b1;
                frame_done_q <= SINGLE;
            end else if (state_q == SEND) begin
                if (last_cyc) begin
                    // Frame finished with nothing queued: go quiet, x_out keeps its value.
                    state_q      <= IDLE;
                    x_valid_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end else begin
                    cnt_q        <= cnt_d;
                    x_out_q      <= buf_q[cnt_d];
                    frame_done_q <= (cnt_d == LAST);
                end
            end

            // A set condition beats a simultaneous clear.
            if (overflow)
                err_overflow_q <= 1'b1;
            else if (bus.err_clr)
                err_overflow_q <= 1'b0;

            if (part)
                err_partial_q <= 1'b1;
            else if (bus.err_clr)
                err_partial_q <= 1'b0;
        end
    end

    assign bus.x_valid      = x_valid_q;
    assign bus.x_out        = x_out_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_partial  = err_partial_q;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: an NN=4 and an NN=1 instance share the clock,
// reset and stimulus. A queue-style model of the pending output stream is
// checked every cycle, alongside a vector table and a few hand sequences.
module tb_layer_seq_ctrl;
    localparam logic [63:0] D1 = 64'h0044_0033_0022_0011;
    localparam logic [63:0] D2 = 64'h000D_000C_000B_000A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  v_r = '0;
    logic [63:0] d_r = '0;
    logic        clr_r = 1'b0;

    always #5 clk = ~clk;

    layer_seq_ctrl_if #(.NN(4), .dataWidth(16)) b4 ();
    layer_seq_ctrl_if #(.NN(1), .dataWidth(16)) b1 ();

    assign b4.in_valid = v_r;
    assign b4.in_data  = d_r;
    assign b4.err_clr  = clr_r;
    assign b1.in_valid = v_r[0];
    assign b1.in_data  = d_r[15:0];
    assign b1.err_clr  = clr_r;

    layer_seq_ctrl #(.NN(4), .dataWidth(16)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    layer_seq_ctrl #(.NN(1), .dataWidth(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: list of words still owed to the consumer plus what is on the outputs now.
    typedef struct {
        logic [15:0] w [8];
        bit          lst [8];
        int          n;
        bit          xv;
        logic [15:0] x;
        bit          fd;
        bit          ov;
        bit          pt;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        for (int k = 0; k < 8; k++) begin
            m.w[k] = '0;
            m.lst[k] = 1'b0;
        end
        m.n = 0; m.xv = 0; m.x = '0; m.fd = 0; m.ov = 0; m.pt = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t mi, int nn, logic [3:0] v, logic [63:0] d, logic clr);
        mdl_t m;
        logic [3:0] mask;
        logic [3:0] vv;
        bit cap, part, ovs;
        m    = mi;
        mask = (nn == 4) ? 4'hF : 4'h1;
        vv   = v & mask;
        cap  = (vv == mask);
        part = (vv != 4'h0) && !cap;
        ovs  = cap && (m.n > 0);
        if (cap && m.n == 0) begin
            for (int k = 0; k < nn; k++) begin
                m.w[k]   = d[k*16 +: 16];
                m.lst[k] = (k == nn - 1);
            end
            m.n = nn;
        end
        if (m.n > 0) begin
            m.xv = 1; m.x = m.w[0]; m.fd = m.lst[0];
            for (int k = 0; k < 7; k++) begin
                m.w[k] = m.w[k+1];
                m.lst[k] = m.lst[k+1];
            end
            m.n--;
        end else begin
            m.xv = 0; m.fd = 0;
        end
        m.ov = ovs  ? 1'b1 : (clr ? 1'b0 : m.ov);
        m.pt = part ? 1'b1 : (clr ? 1'b0 : m.pt);
        return m;
    endfunction

    mdl_t m4, m1;

    task automatic check_models();
        chk("d4 x_valid", b4.x_valid, m4.xv);
        chk("d4 x_out", b4.x_out, m4.x);
        chk("d4 busy", b4.busy, m4.xv);
        chk("d4 frame_done", b4.frame_done, m4.fd);
        chk("d4 err_overflow", b4.err_overflow, m4.ov);
        chk("d4 err_partial", b4.err_partial, m4.pt);
        chk("d1 x_valid", b1.x_valid, m1.xv);
        chk("d1 x_out", b1.x_out, m1.x);
        chk("d1 busy", b1.busy, m1.xv);
        chk("d1 frame_done", b1.frame_done, m1.fd);
        chk("d1 err_overflow", b1.err_overflow, m1.ov);
        chk("d1 err_partial", b1.err_partial, m1.pt);
    endtask

    // One clock: advance the model on the edge, then compare away from it.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m4 = mreset();
            m1 = mreset();
        end else begin
            m4 = mstep(m4, 4, v_r, d_r, clr_r);
            m1 = mstep(m1, 1, v_r, d_r, clr_r);
        end
        #1;
        check_models();
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        logic        clr;
        logic        xv;
        logic [15:0] x;
        logic        fd;
        logic        busy;
        logic        ov;
        logic        pt;
    } vec_t;

    vec_t tbl [7];

    logic [15:0] seen [16];
    int nv, nfd, first, lastv;

    initial begin
        m4 = mreset();
        m1 = mreset();

        // Reset state
        cycle();
        cycle();
        chk("reset x_valid", b4.x_valid, 1'b0);
        chk("reset x_out", b4.x_out, 16'h0);
        chk("reset busy", b4.busy, 1'b0);
        #2 rst = 1'b0;

        // Single frame, then a partial-strobe cycle and a flag clear
        tbl[0] = '{4'hF, D1, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{4'h0, D1, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'h0, D1, 1'b0, 1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'h0, D1, 1'b0, 1'b1, 16'h0044, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'h0, D1, 1'b0, 1'b0, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{4'h7, D2, 1'b0, 1'b0, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'h0, D2, 1'b1, 1'b0, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            v_r = tbl[i].v; d_r = tbl[i].d; clr_r = tbl[i].clr;
            cycle();
            chk($sformatf("tbl[%0d] x_valid", i), b4.x_valid, tbl[i].xv);
            chk($sformatf("tbl[%0d] x_out", i), b4.x_out, tbl[i].x);
            chk($sformatf("tbl[%0d] frame_done", i), b4.frame_done, tbl[i].fd);
            chk($sformatf("tbl[%0d] busy", i), b4.busy, tbl[i].busy);
            chk($sformatf("tbl[%0d] err_overflow", i), b4.err_overflow, tbl[i].ov);
            chk($sformatf("tbl[%0d] err_partial", i), b4.err_partial, tbl[i].pt);
        end
        clr_r = 1'b0; v_r = '0;

        // Back-to-back: second capture while word 3 is on the output
        nv = 0; nfd = 0; first = -1; lastv = -1;
        for (int i = 0; i < 12; i++) begin
            v_r = (i == 0 || i == 4) ? 4'hF : 4'h0;
            d_r = (i == 4) ? D2 : D1;
            cycle();
            if (b4.x_valid) begin
                if (nv < 16) seen[nv] = b4.x_out;
                if (first < 0) first = i;
                lastv = i;
                nv++;
            end
            if (b4.frame_done) nfd++;
        end
        chk("b2b valid count", nv, 8);
        chk("b2b gapless span", lastv - first + 1, 8);
        chk("b2b frame_done count", nfd, 2);
        chk("b2b word4", seen[4], 16'h000A);
        chk("b2b word7", seen[7], 16'h000D);

        // Overflow: capture while word 1 is on the output is dropped
        nv = 0;
        for (int i = 0; i < 7; i++) begin
            v_r = (i == 0 || i == 2) ? 4'hF : 4'h0;
            d_r = (i == 2) ? D2 : D1;
            cycle();
            if (b4.x_valid) begin
                if (nv < 16) seen[nv] = b4.x_out;
                nv++;
            end
        end
        chk("ovf valid count", nv, 4);
        chk("ovf word1", seen[1], 16'h0022);
        chk("ovf word3", seen[3], 16'h0044);
        chk("ovf flag set", b4.err_overflow, 1'b1);
        v_r = '0; clr_r = 1'b1;
        cycle();
        chk("ovf flag cleared", b4.err_overflow, 1'b0);
        clr_r = 1'b0;

        // Reset mid-frame (word 2 showing) with a sticky flag set
        v_r = 4'h3; cycle();
        v_r = 4'hF; d_r = D1; cycle();
        v_r = 4'h0; cycle(); cycle();
        chk("pre-rst word2", b4.x_out, 16'h0033);
        rst = 1'b1;
        #1;
        chk("async rst x_valid", b4.x_valid, 1'b0);
        chk("async rst busy", b4.busy, 1'b0);
        chk("async rst frame_done", b4.frame_done, 1'b0);
        chk("async rst err_partial", b4.err_partial, 1'b0);
        chk("async rst err_overflow", b4.err_overflow, 1'b0);
        chk("async rst x_out", b4.x_out, 16'h0);
        v_r = 4'hF; d_r = D2;
        cycle();
        chk("cap under rst ignored", b4.x_valid, 1'b0);
        rst = 1'b0;
        cycle();
        chk("post-rst first word", b4.x_out, 16'h000A);
        chk("post-rst x_valid", b4.x_valid, 1'b1);
        v_r = '0;
        for (int i = 0; i < 4; i++) cycle();

        // NN=1: single cycle frame
        v_r = 4'h1; d_r = 64'h7FFF;
        cycle();
        chk("nn1 x_valid", b1.x_valid, 1'b1);
        chk("nn1 x_out", b1.x_out, 16'h7FFF);
        chk("nn1 frame_done", b1.frame_done, 1'b1);
        v_r = '0;
        cycle();
        chk("nn1 idle x_valid", b1.x_valid, 1'b0);
        chk("nn1 hold x_out", b1.x_out, 16'h7FFF);
        clr_r = 1'b1; cycle(); clr_r = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 59) == 0);
            v_r   = (r < 3) ? 4'h0 : (r < 6) ? 4'hF : (r == 6) ? 4'($urandom) : 4'h1;
            d_r   = {$urandom, $urandom};
            clr_r = ($urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 1'b0; v_r = '0; clr_r = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 SHALL have parameter NN, default 30: number of neurons in the producing layer, i.e. the number of words per frame.
REQ-002 SHALL have parameter dataWidth, default 16: width of each neuron output word.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, NN bits: per-neuron output-valid strobes from the producing layer.
REQ-006 SHALL have port in_data, input, NN*dataWidth bits: packed neuron outputs; word k occupies bits [k*dataWidth +: dataWidth].
REQ-007 SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-008 SHALL have port x_valid, output, 1 bit: serial word valid to the consuming layer.
REQ-009 SHALL have port x_out, output, dataWidth bits: serial word to the consuming layer.
REQ-010 SHALL have port busy, output, 1 bit: high while in state SEND.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last word of a frame.
REQ-012 SHALL have port err_overflow, output, 1 bit: sticky flag, set when a frame is dropped.
REQ-013 SHALL have port err_partial, output, 1 bit: sticky flag, set when the valid strobes are inconsistent.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and SEND, registered, with no combinational input-to-output paths.
REQ-015 SHALL define the capture event cap = &in_valid, i.e. all NN strobes high in the same cycle.
REQ-016 In IDLE, cap SHALL latch all NN words of in_data into an internal buffer, set word counter cnt to 0 and enter SEND.
REQ-017 In SEND, each cycle SHALL drive x_valid=1 and x_out=buffer[cnt] (registered), then increment cnt.
REQ-018 Latency: for a capture edge at cycle T, x_valid SHALL be high in cycles T+1 .. T+NN with words 0..NN-1 in order, one per cycle, with no gaps.
REQ-019 SHALL assert frame_done in the same cycle as word NN-1.
REQ-020 SHALL leave cnt at NN-1 only in the last SEND cycle and SHALL never let it exceed NN-1.
REQ-021 At the end of a frame, with no cap in the last SEND cycle, SHALL return to IDLE and drive x_valid=0 from the next cycle.
REQ-022 Back-to-back: cap in the last SEND cycle (cnt==NN-1) SHALL re-capture the buffer, reset cnt to 0 and stay in SEND, giving a gapless stream of 2*NN words.
REQ-023 Overflow: cap in SEND with cnt<NN-1 SHALL be ignored, leave the buffer and stream unaffected, and set err_overflow.
REQ-024 Partial valid: (|in_valid) & ~(&in_valid) in any state SHALL set err_partial and SHALL NOT capture.
REQ-025 When x_valid=0, x_out SHALL hold its last value.
REQ-026 err_clr SHALL clear both error flags at the next edge.
REQ-027 A set condition coincident with err_clr SHALL win, leaving the flag set.
REQ-028 For NN=1, each frame SHALL be a single SEND cycle with frame_done=1.
REQ-029 SHALL support any NN>=1; cnt width SHALL be max(1, clog2(NN)).

Reset
REQ-030 While rst=1, SHALL force state=IDLE, cnt=0, x_valid=0, x_out=0, busy=0, frame_done=0, err_overflow=0, err_partial=0; the buffer contents are don't-care.
REQ-031 rst asserted mid-frame SHALL abort the frame immediately (asynchronously) with no further x_valid.
REQ-032 After rst deasserts, the first cap SHALL start a fresh frame at word 0.
REQ-033 A cap coincident with rst SHALL be ignored.

Verification
REQ-034 NN=4, dataWidth=16, in_data words {0x0011,0x0022,0x0033,0x0044}, in_valid=4'hF for 1 cycle at T -> x_valid high T+1..T+4 with 0x0011, 0x0022, 0x0033, 0x0044; frame_done at T+4; busy low at T+5.
REQ-035 Second cap at cnt==3 with words {0xA..0xD} -> 8 consecutive valid words, the second frame starting at 0x000A, exactly two frame_done pulses.
REQ-036 Cap at cnt==1 -> first frame streams unchanged, err_overflow=1; err_clr pulse -> err_overflow=0 next cycle.
REQ-037 in_valid=4'b0111 for 1 cycle -> no x_valid, err_partial=1.
REQ-038 rst pulse at cnt==2 -> x_valid=0 immediately, all flags 0; next cap -> word 0 first.
REQ-039 NN=1: cap with data 0x7FFF -> single valid cycle carrying 0x7FFF with frame_done=1.
